fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC register, 2-entry {pc, instr} fetch queue, redirect/flush, RUN/FAULT FSM.
// Optional fetch range check enabled by defining FETCH_RANGE_CHECK_EN.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 8192
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] im_pc,
  input  logic [31:0] im_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

`ifdef FETCH_RANGE_CHECK_EN
  localparam logic LP_RC_EN = 1'b1;
`else
  localparam logic LP_RC_EN = 1'b0;
`endif

  // Bounds widened to 33 bits so RESET_PC + 4*IM_WORDS cannot wrap.
  localparam logic [32:0] LP_PC_LO = {1'b0, RESET_PC};
  localparam logic [32:0] LP_PC_HI = LP_PC_LO + (33'(IM_WORDS) * 33'd4);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [1:0]  r_count;
  logic [31:0] r_hd_pc;
  logic [31:0] r_hd_instr;
  logic [31:0] r_tl_pc;
  logic [31:0] r_tl_instr;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  logic        w_oob;
  logic        w_range_fault;
  logic        w_pop;
  logic        w_push;
  logic        w_enter_fault;
  logic [31:0] w_pc_nxt;
  logic [1:0]  w_count_nxt;
  logic [31:0] w_hd_pc_nxt;
  logic [31:0] w_hd_instr_nxt;
  logic [31:0] w_tl_pc_nxt;
  logic [31:0] w_tl_instr_nxt;
  logic        w_fault_nxt;
  logic [31:0] w_fault_pc_nxt;

  assign im_pc     = r_pc;
  assign out_valid = (r_count != 2'd0);
  assign out_pc    = r_hd_pc;
  assign out_instr = r_hd_instr;
  assign fault     = r_fault & LP_RC_EN;
  assign fault_pc  = LP_RC_EN ? r_fault_pc : 32'h0000_0000;

  // Range check and handshake qualifiers.
  always_comb begin
    w_oob = ({1'b0, r_pc} < LP_PC_LO) | ({1'b0, r_pc} >= LP_PC_HI) | (r_pc[1:0] != 2'b00);
    w_range_fault = LP_RC_EN & w_oob;
    w_pop  = out_valid & out_ready;
    w_push = (r_state == ST_RUN) & ~redirect_valid & ((r_count < 2'd2) | w_pop) & ~w_range_fault;
  end

  // Next-state logic for the RUN/FAULT FSM.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (w_range_fault && !redirect_valid) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (redirect_valid) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_FAULT;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
    w_enter_fault = (r_state == ST_RUN) && (w_state_nxt == ST_FAULT);
  end

  // Next PC, queue contents and fault capture; redirect overrides everything.
  always_comb begin
    w_pc_nxt       = r_pc;
    w_count_nxt    = r_count;
    w_hd_pc_nxt    = r_hd_pc;
    w_hd_instr_nxt = r_hd_instr;
    w_tl_pc_nxt    = r_tl_pc;
    w_tl_instr_nxt = r_tl_instr;
    w_fault_nxt    = r_fault;
    w_fault_pc_nxt = r_fault_pc;
    if (redirect_valid) begin
      w_pc_nxt    = redirect_pc;
      w_count_nxt = 2'd0;
      w_fault_nxt = 1'b0;
    end else begin
      if (w_push) begin
        w_pc_nxt = r_pc + 32'd4;
      end else begin
        w_pc_nxt = r_pc;
      end
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd2) begin
            w_hd_pc_nxt    = r_tl_pc;
            w_hd_instr_nxt = r_tl_instr;
            w_tl_pc_nxt    = r_pc;
            w_tl_instr_nxt = im_instr;
          end else begin
            w_hd_pc_nxt    = r_pc;
            w_hd_instr_nxt = im_instr;
          end
        end
        2'b01: begin
          w_hd_pc_nxt    = r_tl_pc;
          w_hd_instr_nxt = r_tl_instr;
          w_count_nxt    = r_count - 2'd1;
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            w_hd_pc_nxt    = r_pc;
            w_hd_instr_nxt = im_instr;
          end else begin
            w_tl_pc_nxt    = r_pc;
            w_tl_instr_nxt = im_instr;
          end
          w_count_nxt = r_count + 2'd1;
        end
        default: w_count_nxt = r_count;
      endcase
      if (w_enter_fault) begin
        w_fault_nxt    = 1'b1;
        w_fault_pc_nxt = r_pc;
      end else begin
        w_fault_nxt    = r_fault;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_RUN;
      r_pc       <= RESET_PC;
      r_count    <= 2'd0;
      r_hd_pc    <= 32'h0000_0000;
      r_hd_instr <= 32'h0000_0000;
      r_tl_pc    <= 32'h0000_0000;
      r_tl_instr <= 32'h0000_0000;
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_count    <= w_count_nxt;
      r_hd_pc    <= w_hd_pc_nxt;
      r_hd_instr <= w_hd_instr_nxt;
      r_tl_pc    <= w_tl_pc_nxt;
      r_tl_instr <= w_tl_instr_nxt;
      r_fault    <= w_fault_nxt;
      r_fault_pc <= w_fault_pc_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: stimulus queues expected {pc, instr}, a negedge monitor checks each handshake.
module tb_fetch_ctrl;

  localparam logic [31:0] K_INSTR = 32'h5A5A_0F0F;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] im_pc;
  logic [31:0] im_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .im_pc          (im_pc),
    .im_instr       (im_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // Instruction memory model: word content derived from its address.
  assign im_instr = im_pc ^ K_INSTR;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = pc ^ K_INSTR;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input logic ready);
    reset          = 1'b0;
    redirect_valid = 1'b0;
    out_ready      = ready;
    tick();
    tick();
    reset = 1'b1;
  endtask

  // Monitor: every accepted head entry must match the next expected entry.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected actual_pc=%h required=none", out_pc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_instr", out_instr, e.instr);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset          = 1'b1;
    out_ready      = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    #1 reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 32'd0);
    chk("rst_im_pc", im_pc, 32'h3000);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_fault", fault, 32'd0);
    chk("rst_fault_pc", fault_pc, 32'h0);

    // Streaming with out_ready held high.
    tick();
    tick();
    reset = 1'b1;
    exp_push(32'h3000); exp_push(32'h3004); exp_push(32'h3008);
    tick(); chk("stream_pc0", out_pc, 32'h3000);
    tick(); chk("stream_pc1", out_pc, 32'h3004);
    tick(); chk("stream_pc2", out_pc, 32'h3008);
    tick();
    out_ready = 1'b0;
    chk("stream_drained", 32'(sb_q.size()), 32'd0);

    // Backpressure: queue saturates at two entries, then drains without a gap.
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) tick();
    chk("bp_im_pc", im_pc, 32'h3008);
    chk("bp_out_pc", out_pc, 32'h3000);
    chk("bp_out_valid", out_valid, 32'd1);
    exp_push(32'h3000); exp_push(32'h3004); exp_push(32'h3008);
    out_ready = 1'b1;
    tick(); chk("bp_pc1", out_pc, 32'h3004);
    tick(); chk("bp_pc2", out_pc, 32'h3008);
    tick();
    out_ready = 1'b0;
    chk("bp_drained", 32'(sb_q.size()), 32'd0);

    // Redirect while full; the head popped in that cycle is consumed.
    do_reset(1'b0);
    tick(); tick(); tick();
    exp_push(32'h3000);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3100;
    out_ready      = 1'b1;
    tick();
    redirect_valid = 1'b0;
    chk("redir_out_valid", out_valid, 32'd0);
    chk("redir_im_pc", im_pc, 32'h3100);
    exp_push(32'h3100); exp_push(32'h3104);
    tick(); chk("redir_out_pc", out_pc, 32'h3100);
    tick();
    tick();
    out_ready = 1'b0;
    chk("redir_drained", 32'(sb_q.size()), 32'd0);

    // Misaligned redirect target, then recovery.
    do_reset(1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3002;
    tick();
    redirect_valid = 1'b0;
    chk("mis_im_pc", im_pc, 32'h3002);
    chk("mis_out_valid0", out_valid, 32'd0);
    tick();
`ifdef FETCH_RANGE_CHECK_EN
    chk("mis_fault", fault, 32'd1);
    chk("mis_fault_pc", fault_pc, 32'h3002);
    chk("mis_out_valid", out_valid, 32'd0);
`else
    chk("mis_fault", fault, 32'd0);
    chk("mis_out_valid", out_valid, 32'd1);
    chk("mis_out_pc", out_pc, 32'h3002);
`endif
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3000;
    tick();
    redirect_valid = 1'b0;
    chk("rec_fault", fault, 32'd0);
    chk("rec_out_valid0", out_valid, 32'd0);
    tick();
    chk("rec_out_valid", out_valid, 32'd1);
    chk("rec_out_pc", out_pc, 32'h3000);
    chk("rec_out_instr", out_instr, 32'h3000 ^ K_INSTR);

    // Sequential fetch across the top of instruction memory.
    do_reset(1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hAFF8;
    tick();
    redirect_valid = 1'b0;
    exp_push(32'hAFF8); exp_push(32'hAFFC);
    out_ready = 1'b1;
    tick(); tick(); tick();
    out_ready = 1'b0;
`ifdef FETCH_RANGE_CHECK_EN
    chk("top_fault", fault, 32'd1);
    chk("top_fault_pc", fault_pc, 32'hB000);
    chk("top_out_valid", out_valid, 32'd0);
    chk("top_im_pc", im_pc, 32'hB000);
    tick();
    chk("top_im_pc_hold", im_pc, 32'hB000);
`else
    chk("top_fault", fault, 32'd0);
    chk("top_out_valid", out_valid, 32'd1);
    chk("top_out_pc", out_pc, 32'hB000);
    chk("top_im_pc", im_pc, 32'hB004);
    tick();
    chk("top_im_pc_next", im_pc, 32'hB008);
`endif
    chk("top_drained", 32'(sb_q.size()), 32'd0);

    // PC arithmetic at the 32-bit boundary.
    do_reset(1'b0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
`ifdef FETCH_RANGE_CHECK_EN
    chk("wrap_fault", fault, 32'd1);
    chk("wrap_fault_pc", fault_pc, 32'hFFFF_FFFC);
`else
    chk("wrap_im_pc", im_pc, 32'h0);
    chk("wrap_out_pc", out_pc, 32'hFFFF_FFFC);
`endif

    // Asynchronous reset in the middle of a full queue.
    do_reset(1'b0);
    tick(); tick(); tick();
    chk("mid_pre_valid", out_valid, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_out_valid", out_valid, 32'd0);
    chk("mid_im_pc", im_pc, 32'h3000);
    chk("mid_out_pc", out_pc, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    chk("post_out_valid", out_valid, 32'd1);
    chk("post_out_pc", out_pc, 32'h3000);

    chk("final_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
